char_move_ctrl: RTL and testbench
=================================

Name: char_move_ctrl

Overview:
- Player movement controller sitting directly upstream of the collision detector.
- Converts the per-step movement command into a candidate direction and raises collision_enable for the lookup window.
- Samples the resulting c_map_collision / c_e1_collision flags, then commits or rejects the 1-px move on char_x/char_y.
- Also generates the step rate, edge clamping, and an enemy-contact hit pulse with cooldown.

Parameters:
- START_X, 152, reset x position (9-bit).
- START_Y, 112, reset y position (8-bit).
- X_MAX, 303, largest legal char_x (320 − 17).
- Y_MAX, 223, largest legal char_y (240 − 17).
- STEP_DIV, 833333, clock cycles per movement step (60 Hz at 50 MHz); must be ≥ LOOKUP_WAIT+4.
- LOOKUP_WAIT, 2, cycles between direction presentation and valid collision flags (levelmap synchronous read + margin).
- HIT_COOLDOWN, 30, steps after a hit during which char_hit is suppressed.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- move_cmd  in  3  requested action: NO_ACTION=000, ATTACK=001, UP=010, DOWN=011, LEFT=100, RIGHT=101; others treated as NO_ACTION.
- c_map_collision  in  1  from collision detector: candidate position overlaps a wall.
- c_e1_collision  in  1  from collision detector: player/enemy1 boxes overlap (<16 px on both axes).
- char_x  out  9  player x position.
- char_y  out  8  player y position.
- direction_char  out  3  candidate direction presented to collision detector.
- facing_char  out  3  last movement direction (UP..RIGHT only).
- collision_enable  out  1  collision detector enable.
- char_blocked  out  1  one-cycle pulse: move rejected (wall or screen edge).
- char_hit  out  1  one-cycle pulse: enemy contact outside cooldown.
- busy  out  1  high whenever FSM is not IDLE.

Behaviour:
Reset (reset==0 at a clock edge) forces:
- char_x=START_X, char_y=START_Y, direction_char=NO_ACTION, facing_char=DOWN.
- collision_enable=0, char_blocked=0, char_hit=0, busy=0.
- step counter=0, step_pending=0, cooldown=0, state=IDLE.
- Applies mid-operation too; any in-flight move is discarded.

Step timer:
- Counter 0..STEP_DIV-1, free-running, wraps to 0.
- At terminal count sets step_pending.
- Pending ticks do not queue: ticks arriving while step_pending=1 are dropped.
- If a tick and consumption coincide, consumption wins and the tick sets pending again.
- On each tick, cooldown decrements if non-zero (saturates at 0).

FSM states: IDLE, REQ, WAIT, EVAL.
- IDLE:
  - If step_pending: clear it and latch move_cmd.
  - NO_ACTION/ATTACK/illegal: stay IDLE; direction_char=latched value; no lookup; position unchanged.
  - Move toward an edge already at the limit (UP with y==0, LEFT with x==0, DOWN with y==Y_MAX, RIGHT with x==X_MAX): stay IDLE, pulse char_blocked next cycle, facing_char updated, no lookup. No wrap-around ever.
  - Otherwise: direction_char=cmd, facing_char=cmd, go to REQ.
- REQ: collision_enable=1, one cycle, then WAIT with wait counter=0.
- WAIT: collision_enable=1; counts LOOKUP_WAIT cycles, then EVAL.
- EVAL: collision_enable=1, one cycle; samples flags.
  - If c_e1_collision and cooldown==0: char_hit pulses (registered, visible the cycle after EVAL); cooldown=HIT_COOLDOWN.
  - If c_map_collision or c_e1_collision: position unchanged; char_blocked pulses.
  - Otherwise ±1 on the relevant axis; new value visible the cycle after EVAL.
  - Then IDLE; collision_enable drops to 0 in IDLE.
- Latency: REQ entry to updated position = LOOKUP_WAIT+2 cycles.
- char_x/char_y are stable throughout REQ..EVAL, so the detector sees a consistent current position.
- direction_char holds its value after EVAL until the next latched command.
- move_cmd changes during REQ..EVAL are ignored.
- Blocked and hit in the same EVAL: both pulses fire in the same cycle.

Test Plan (STEP_DIV=8, LOOKUP_WAIT=2, HIT_COOLDOWN=3):
- Hold reset=0 then release -> char_x=152, char_y=112, facing=DOWN, all pulses 0; first step_pending after 8 cycles.
- move_cmd=RIGHT, flags 0 -> collision_enable high exactly 4 cycles (REQ+2 WAIT+EVAL); char_x=153 the cycle after EVAL; five steps -> 157.
- move_cmd=UP, c_map_collision=1 during EVAL -> char_y unchanged, one char_blocked pulse, facing_char=UP.
- Preload char_x=0 via START_X=0; move_cmd=LEFT -> collision_enable never asserts, char_blocked pulses, char_x stays 0. Same for char_y=Y_MAX with DOWN.
- c_e1_collision=1 held, move_cmd=DOWN for 6 steps -> char_hit on steps 1 and 5 only; char_y unchanged all 6 steps.
- Assert reset=0 during WAIT -> next cycle state IDLE, collision_enable=0, position back to START_X/START_Y, no pulses.

Source files
------------

// File: rtl/char_move_ctrl_if.sv
// Signal bundle between the player movement controller and its environment:
// the command source on one side and the collision detector on the other.
interface char_move_ctrl_if;
    logic [2:0] move_cmd;
    logic       c_map_collision;
    logic       c_e1_collision;
    logic [8:0] char_x;
    logic [7:0] char_y;
    logic [2:0] direction_char;
    logic [2:0] facing_char;
    logic       collision_enable;
    logic       char_blocked;
    logic       char_hit;
    logic       busy;

    modport master (
        input  move_cmd, c_map_collision, c_e1_collision,
        output char_x, char_y, direction_char, facing_char,
               collision_enable, char_blocked, char_hit, busy
    );

    modport slave (
        output move_cmd, c_map_collision, c_e1_collision,
        input  char_x, char_y, direction_char, facing_char,
               collision_enable, char_blocked, char_hit, busy
    );
endinterface

// File: rtl/char_move_ctrl.sv
// Player movement controller: paces steps, asks the collision detector about the
// candidate move, then commits or rejects a 1-px move and flags enemy contact.
module char_move_ctrl #(
    parameter int START_X      = 152,
    parameter int START_Y      = 112,
    parameter int X_MAX        = 303,
    parameter int Y_MAX        = 223,
    parameter int STEP_DIV     = 833333,
    parameter int LOOKUP_WAIT  = 2,
    parameter int HIT_COOLDOWN = 30
) (
    input  logic             clock,
    input  logic             reset,
    char_move_ctrl_if.master bus
);
    localparam logic [2:0] CMD_NONE   = 3'd0;
    localparam logic [2:0] CMD_ATTACK = 3'd1;
    localparam logic [2:0] CMD_UP     = 3'd2;
    localparam logic [2:0] CMD_DOWN   = 3'd3;
    localparam logic [2:0] CMD_LEFT   = 3'd4;
    localparam logic [2:0] CMD_RIGHT  = 3'd5;

    localparam int CNT_W  = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
    localparam int WAIT_W = (LOOKUP_WAIT > 2) ? $clog2(LOOKUP_WAIT) : 1;
    localparam int CD_W   = (HIT_COOLDOWN > 1) ? $clog2(HIT_COOLDOWN + 1) : 1;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_EVAL} state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                pend_q, pend_d;
    logic [CD_W-1:0]     cd_q, cd_d;
    logic                hit_ok_q, hit_ok_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [8:0]          x_q, x_d;
    logic [7:0]          y_q, y_d;
    logic [2:0]          dir_q, dir_d;
    logic [2:0]          face_q, face_d;
    logic                blocked_q, blocked_d;
    logic                hit_q, hit_d;

    logic tick;
    logic consume;
    logic is_move;
    logic at_edge;
    logic start_move;

    assign tick       = (cnt_q == CNT_W'(STEP_DIV - 1));
    assign consume    = (state_q == S_IDLE) && pend_q;
    assign is_move    = (bus.move_cmd >= CMD_UP) && (bus.move_cmd <= CMD_RIGHT);
    assign start_move = consume && is_move && !at_edge;

    always_comb begin
        at_edge = 1'b0;
        case (bus.move_cmd)
            CMD_UP:    at_edge = (y_q == 8'd0);
            CMD_DOWN:  at_edge = (y_q == 8'(Y_MAX));
            CMD_LEFT:  at_edge = (x_q == 9'd0);
            CMD_RIGHT: at_edge = (x_q == 9'(X_MAX));
            default:   at_edge = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start_move) state_d = S_REQ;
            S_REQ:  state_d = (LOOKUP_WAIT == 0) ? S_EVAL : S_WAIT;
            S_WAIT: if (wait_q == WAIT_W'(LOOKUP_WAIT - 1)) state_d = S_EVAL;
            S_EVAL: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.collision_enable = (state_q != S_IDLE);
        bus.busy             = (state_q != S_IDLE);
    end

    always_comb begin
        cnt_d     = tick ? '0 : cnt_q + 1'b1;
        pend_d    = pend_q;
        cd_d      = cd_q;
        hit_ok_d  = hit_ok_q;
        wait_d    = (state_q == S_WAIT) ? wait_q + 1'b1 : '0;
        x_d       = x_q;
        y_d       = y_q;
        dir_d     = dir_q;
        face_d    = face_q;
        blocked_d = 1'b0;
        hit_d     = 1'b0;

        if (consume) pend_d = 1'b0;
        if (tick) begin
            pend_d = 1'b1;
            // Hit permission is judged on the cooldown before this step's decrement,
            // so a hit suppresses exactly the HIT_COOLDOWN steps that follow it.
            hit_ok_d = (cd_q == '0);
            if (cd_q != '0) cd_d = cd_q - 1'b1;
        end

        if (consume) begin
            if (is_move) begin
                dir_d  = bus.move_cmd;
                face_d = bus.move_cmd;
                if (at_edge) blocked_d = 1'b1;
            end else begin
                dir_d = (bus.move_cmd == CMD_ATTACK) ? CMD_ATTACK : CMD_NONE;
            end
        end

        if (state_q == S_EVAL) begin
            if (bus.c_e1_collision && hit_ok_q) begin
                hit_d    = 1'b1;
                cd_d     = CD_W'(HIT_COOLDOWN);
                hit_ok_d = 1'b0;
            end
            if (bus.c_map_collision || bus.c_e1_collision) begin
                blocked_d = 1'b1;
            end else begin
                case (dir_q)
                    CMD_UP:    y_d = y_q - 8'd1;
                    CMD_DOWN:  y_d = y_q + 8'd1;
                    CMD_LEFT:  x_d = x_q - 9'd1;
                    CMD_RIGHT: x_d = x_q + 9'd1;
                    default:   ;
                endcase
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt_q     <= '0;
            pend_q    <= 1'b0;
            cd_q      <= '0;
            hit_ok_q  <= 1'b1;
            wait_q    <= '0;
            x_q       <= 9'(START_X);
            y_q       <= 8'(START_Y);
            dir_q     <= CMD_NONE;
            face_q    <= CMD_DOWN;
            blocked_q <= 1'b0;
            hit_q     <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            pend_q    <= pend_d;
            cd_q      <= cd_d;
            hit_ok_q  <= hit_ok_d;
            wait_q    <= wait_d;
            x_q       <= x_d;
            y_q       <= y_d;
            dir_q     <= dir_d;
            face_q    <= face_d;
            blocked_q <= blocked_d;
            hit_q     <= hit_d;
        end
    end

    assign bus.char_x         = x_q;
    assign bus.char_y         = y_q;
    assign bus.direction_char = dir_q;
    assign bus.facing_char    = face_q;
    assign bus.char_blocked   = blocked_q;
    assign bus.char_hit       = hit_q;
endmodule

// File: tb/tb_char_move_ctrl.sv
// Bench for char_move_ctrl: two instances (centre start and corner start) driven by
// directed step commands; a scoreboard checks every completed step result.
module tb_char_move_ctrl;
    localparam logic [2:0] NONE = 3'd0, ATK = 3'd1, UP = 3'd2, DN = 3'd3, LT = 3'd4, RT = 3'd5;

    typedef struct packed {
        logic [8:0] x;
        logic [7:0] y;
        logic [2:0] face;
        logic       blk;
        logic       hit;
        logic [3:0] en;
    } res_t;

    logic       clk;
    logic       rst_a [2];
    logic [2:0] cmd_a [2];
    logic       map_a [2];
    logic       e1_a  [2];
    logic [8:0] x_a   [2];
    logic [7:0] y_a   [2];
    logic [2:0] dir_a [2];
    logic [2:0] face_a[2];
    logic       en_a  [2];
    logic       blk_a [2];
    logic       hit_a [2];
    logic       busy_a[2];

    res_t exp_q[2][$];
    int   ev_cnt[2];
    int   tests;
    int   fails;

    char_move_ctrl_if bus0 ();
    char_move_ctrl_if bus1 ();

    assign bus0.move_cmd        = cmd_a[0];
    assign bus0.c_map_collision = map_a[0];
    assign bus0.c_e1_collision  = e1_a[0];
    assign bus1.move_cmd        = cmd_a[1];
    assign bus1.c_map_collision = map_a[1];
    assign bus1.c_e1_collision  = e1_a[1];

    assign x_a[0] = bus0.char_x;           assign x_a[1] = bus1.char_x;
    assign y_a[0] = bus0.char_y;           assign y_a[1] = bus1.char_y;
    assign dir_a[0] = bus0.direction_char; assign dir_a[1] = bus1.direction_char;
    assign face_a[0] = bus0.facing_char;   assign face_a[1] = bus1.facing_char;
    assign en_a[0] = bus0.collision_enable; assign en_a[1] = bus1.collision_enable;
    assign blk_a[0] = bus0.char_blocked;   assign blk_a[1] = bus1.char_blocked;
    assign hit_a[0] = bus0.char_hit;       assign hit_a[1] = bus1.char_hit;
    assign busy_a[0] = bus0.busy;          assign busy_a[1] = bus1.busy;

    char_move_ctrl #(
        .START_X(152), .START_Y(112), .X_MAX(303), .Y_MAX(223),
        .STEP_DIV(8), .LOOKUP_WAIT(2), .HIT_COOLDOWN(3)
    ) dut0 (
        .clock(clk), .reset(rst_a[0]), .bus(bus0)
    );

    char_move_ctrl #(
        .START_X(0), .START_Y(223), .X_MAX(303), .Y_MAX(223),
        .STEP_DIV(8), .LOOKUP_WAIT(2), .HIT_COOLDOWN(3)
    ) dut1 (
        .clock(clk), .reset(rst_a[1]), .bus(bus1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic res_t mk(input int x, input int y, input logic [2:0] face,
                                input logic blk, input logic hit, input int en);
        res_t r;
        r.x = 9'(x); r.y = 8'(y); r.face = face; r.blk = blk; r.hit = hit; r.en = 4'(en);
        return r;
    endfunction

    task automatic chk(input string nm, input int got, input int exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    // Scoreboard monitor: a step result is presented either when the lookup window
    // closes or when an edge block pulses without any lookup.
    task automatic monitor();
        int   run[2];
        logic pen[2];
        res_t a, e;
        run = '{0, 0};
        pen = '{1'b0, 1'b0};
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (!rst_a[d]) begin
                    run[d] = 0;
                    pen[d] = 1'b0;
                end else begin
                    if (en_a[d]) begin
                        run[d]++;
                    end else if (pen[d] || blk_a[d]) begin
                        a.x = x_a[d]; a.y = y_a[d]; a.face = face_a[d];
                        a.blk = blk_a[d]; a.hit = hit_a[d]; a.en = 4'(run[d]);
                        tests++;
                        if (exp_q[d].size() == 0) begin
                            fails++;
                            $display("FAIL dut%0d unexpected result x=%0d y=%0d blk=%0d hit=%0d",
                                     d, a.x, a.y, a.blk, a.hit);
                        end else begin
                            e = exp_q[d].pop_front();
                            if (a !== e) begin
                                fails++;
                                $display("FAIL dut%0d step%0d: got x=%0d y=%0d face=%0d blk=%0d hit=%0d en=%0d, expected x=%0d y=%0d face=%0d blk=%0d hit=%0d en=%0d",
                                         d, ev_cnt[d], a.x, a.y, a.face, a.blk, a.hit, a.en,
                                         e.x, e.y, e.face, e.blk, e.hit, e.en);
                            end
                        end
                        ev_cnt[d]++;
                        run[d] = 0;
                    end
                    pen[d] = en_a[d];
                end
            end
        end
    endtask

    task automatic wait_ev(input int d, input int start, input string nm);
        int k;
        k = 0;
        while (ev_cnt[d] == start && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        tests++;
        if (ev_cnt[d] == start) begin
            fails++;
            $display("FAIL %s: no step result within 40 cycles", nm);
            void'(exp_q[d].pop_back());
        end
    endtask

    task automatic step(input int d, input logic [2:0] cmd, input logic m, input logic e,
                        input res_t ex, input string nm);
        int start;
        start = ev_cnt[d];
        exp_q[d].push_back(ex);
        cmd_a[d] = cmd; map_a[d] = m; e1_a[d] = e;
        wait_ev(d, start, nm);
        cmd_a[d] = NONE; map_a[d] = 1'b0; e1_a[d] = 1'b0;
    endtask

    task automatic idle_cycles(input int d, input int n, output logic saw_busy);
        saw_busy = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            saw_busy = saw_busy | busy_a[d];
        end
    endtask

    initial begin
        int   k, start;
        logic bz;
        logic [1:0] hits;

        tests = 0; fails = 0;
        ev_cnt = '{0, 0};
        for (int d = 0; d < 2; d++) begin
            rst_a[d] = 1'b0; cmd_a[d] = NONE; map_a[d] = 1'b0; e1_a[d] = 1'b0;
        end

        fork
            monitor();
            begin
                #100000;
                $display("FAIL watchdog: simulation did not complete");
                $fatal(1, "watchdog");
            end
        join_none

        repeat (3) @(posedge clk);
        #1;
        chk("reset x", x_a[0], 152);
        chk("reset y", y_a[0], 112);
        chk("reset facing", face_a[0], DN);
        chk("reset dir", dir_a[0], NONE);
        chk("reset en", en_a[0], 0);
        chk("reset blk", blk_a[0], 0);
        chk("reset hit", hit_a[0], 0);
        chk("reset busy", busy_a[0], 0);
        chk("reset x dut1", x_a[1], 0);
        chk("reset y dut1", y_a[1], 223);

        // First step: timer needs 8 cycles to raise pending, FSM leaves IDLE one cycle later.
        start = ev_cnt[0];
        exp_q[0].push_back(mk(153, 112, RT, 0, 0, 4));
        cmd_a[0] = RT;
        rst_a[0] = 1'b1; rst_a[1] = 1'b1;
        k = 0;
        while (!busy_a[0] && k < 30) begin
            @(posedge clk); #1;
            k++;
        end
        chk("first step busy cycle", k, 9);
        wait_ev(0, start, "right 1");
        cmd_a[0] = NONE;

        for (int i = 2; i <= 5; i++) step(0, RT, 0, 0, mk(152 + i, 112, RT, 0, 0, 4), "right");
        step(0, UP, 1, 0, mk(157, 112, UP, 1, 0, 4), "up wall");
        step(0, LT, 0, 0, mk(156, 112, LT, 0, 0, 4), "left free");

        hits = 2'b00;
        for (int i = 1; i <= 6; i++) begin
            step(0, DN, 0, 1, mk(156, 112, DN, 1, (i == 1 || i == 5), 4), "down enemy");
        end
        step(0, DN, 0, 0, mk(156, 113, DN, 0, 0, 4), "down free");

        cmd_a[0] = ATK;
        idle_cycles(0, 12, bz);
        chk("attack busy", bz, 0);
        chk("attack dir", dir_a[0], ATK);
        chk("attack facing", face_a[0], DN);
        cmd_a[0] = 3'd7;
        idle_cycles(0, 12, bz);
        chk("illegal busy", bz, 0);
        chk("illegal x", x_a[0], 156);
        chk("illegal y", y_a[0], 113);
        cmd_a[0] = NONE;

        step(1, LT, 0, 0, mk(0, 223, LT, 1, 0, 0), "left at edge");
        step(1, DN, 0, 0, mk(0, 223, DN, 1, 0, 0), "down at edge");
        step(1, UP, 0, 0, mk(0, 222, UP, 0, 0, 4), "up from edge");
        step(1, RT, 0, 0, mk(1, 222, RT, 0, 0, 4), "right from edge");

        // Reset while the lookup is in flight.
        start = ev_cnt[0];
        cmd_a[0] = RT;
        k = 0;
        while (!en_a[0] && k < 30) begin
            @(posedge clk); #1;
            k++;
        end
        chk("lookup started", en_a[0], 1);
        @(posedge clk); #1;
        rst_a[0] = 1'b0;
        cmd_a[0] = NONE;
        @(posedge clk); #1;
        chk("mid reset en", en_a[0], 0);
        chk("mid reset busy", busy_a[0], 0);
        chk("mid reset x", x_a[0], 152);
        chk("mid reset y", y_a[0], 112);
        chk("mid reset blk", blk_a[0], 0);
        chk("mid reset hit", hit_a[0], 0);
        chk("mid reset facing", face_a[0], DN);
        rst_a[0] = 1'b1;
        idle_cycles(0, 20, bz);
        chk("no result after reset", ev_cnt[0], start);
        chk("x after reset idle", x_a[0], 152);

        chk("queue0 drained", exp_q[0].size(), 0);
        chk("queue1 drained", exp_q[1].size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
